// File: rtl/axi_pkg.sv
// Shared AXI4-Lite definitions for the data-side memory slaves: response codes,
// channel FSM state encodings and the byte-lane address shift helper.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  // Number of byte-offset address bits below the word index.
  function automatic int calc_alsb(input int dwidth);
    return (dwidth == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/mem_bank_bytewe.sv
// Word-organised storage with one synchronous read port and one byte-enabled
// write port; contents and read register are not reset.
module mem_bank_bytewe #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0]   wr_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  // Read and write share one edge, so a same-word access returns the old word.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem_q[rd_addr];
    for (int i = 0; i < DW/8; i++) begin
      if (wr_be[i]) mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dmemory_axil.sv
// AXI4-Lite data memory slave with byte strobes and SLVERR decode.
// Optional DMEM_READ_PIPE_EN adds a read output register (2-cycle read latency).
//
// state     | meaning
// R_IDLE    | ARREADY raised, waiting for read address
// R_WAIT    | read data passing through output register (pipe build only)
// R_RESP    | RVALID held with RDATA/RRESP until RREADY
// W_IDLE    | AWREADY and WREADY raised, nothing latched
// W_HAVE_AW | address latched, waiting for write data
// W_HAVE_W  | data/strobes latched, waiting for write address
// W_RESP    | BVALID held with BRESP until BREADY
module dmemory_axil
  import axi_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int AXI_AWIDTH = 12,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,
  input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY
);

  localparam int ALSB = calc_alsb(AXI_DWIDTH);
  localparam int SW   = AXI_DWIDTH / 8;
  localparam int MAW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  function automatic logic addr_err(input logic [AXI_AWIDTH-1:0] a);
    return (a[ALSB-1:0] != '0) || (32'(a[AXI_AWIDTH-1:ALSB]) >= 32'(MEM_DEPTH));
  endfunction

  // ---------------- read channel ----------------
  rd_state_t       rstate_q, rstate_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rerr_q, rerr_d;
  logic            rd_err, ar_hs, mem_rd_en;
  logic [AXI_DWIDTH-1:0] mem_rdata;

  assign rd_err    = addr_err(AXI_ARADDR);
  assign ar_hs     = AXI_ARVALID & arready_q;
  assign mem_rd_en = ar_hs & ~rd_err;

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rerr_d    = rerr_q;
    case (rstate_q)
      R_IDLE: begin
        if (!arready_q) begin
          arready_d = 1'b1;
        end else if (AXI_ARVALID) begin
          arready_d = 1'b0;
          rerr_d    = rd_err;
          rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
`ifdef DMEM_READ_PIPE_EN
          rstate_d  = R_WAIT;
`else
          rvalid_d  = 1'b1;
          rstate_d  = R_RESP;
`endif
        end
      end
      R_WAIT: begin
        rvalid_d = 1'b1;
        rstate_d = R_RESP;
      end
      R_RESP: begin
        if (AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rerr_q    <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rerr_q    <= rerr_d;
    end
  end

`ifdef DMEM_READ_PIPE_EN
  logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rstate_q == R_WAIT) rdata_d = rerr_q ? '0 : mem_rdata;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) rdata_q <= '0;
    else              rdata_q <= rdata_d;
  end

  assign AXI_RDATA = rdata_q;
`else
  // The bank's read register is unreset, so mask it outside a valid OKAY beat.
  assign AXI_RDATA = (rvalid_q && !rerr_q) ? mem_rdata : '0;
`endif

  assign AXI_ARREADY = arready_q;
  assign AXI_RVALID  = rvalid_q;
  assign AXI_RRESP   = rresp_q;

  // ---------------- write channel ----------------
  wr_state_t             wstate_q, wstate_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [AXI_AWIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DWIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  aw_hs, w_hs, wr_fire, wr_err;
  logic [AXI_AWIDTH-1:0] wr_addr;
  logic [AXI_DWIDTH-1:0] wr_data;
  logic [SW-1:0]         wr_strb, wr_be;

  assign aw_hs   = AXI_AWVALID & awready_q;
  assign w_hs    = AXI_WVALID & wready_q;
  assign wr_addr = (wstate_q == W_HAVE_AW) ? awaddr_q : AXI_AWADDR;
  assign wr_data = (wstate_q == W_HAVE_W) ? wdata_q : AXI_WDATA;
  assign wr_strb = (wstate_q == W_HAVE_W) ? wstrb_q : AXI_WSTRB;
  assign wr_err  = addr_err(wr_addr);
  assign wr_be   = (wr_fire && !wr_err) ? wr_strb : '0;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wr_fire   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_fire   = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          wstate_d  = W_RESP;
        end else if (aw_hs) begin
          awaddr_d  = AXI_AWADDR;
          awready_d = 1'b0;
          wstate_d  = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d   = AXI_WDATA;
          wstrb_d   = AXI_WSTRB;
          wready_d  = 1'b0;
          wstate_d  = W_HAVE_W;
        end else begin
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          wr_fire  = 1'b1;
          wready_d = 1'b0;
          wstate_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          wr_fire   = 1'b1;
          awready_d = 1'b0;
          wstate_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_BRESP   = bresp_q;

  mem_bank_bytewe #(
    .DEPTH (MEM_DEPTH),
    .DW    (AXI_DWIDTH),
    .AW    (MAW)
  ) u_bank (
    .clk     (AXI_ACLK),
    .rd_en   (mem_rd_en),
    .rd_addr (AXI_ARADDR[ALSB +: MAW]),
    .rd_data (mem_rdata),
    .wr_addr (wr_addr[ALSB +: MAW]),
    .wr_be   (wr_be),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_dmemory_axil.sv
// Directed bench for dmemory_axil: a vector table of single transactions plus
// hand-written sequences for ordering, backpressure, hazards and reset.
module tb_dmemory_axil;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmemory_axil #(.MEM_DEPTH(1024), .AXI_AWIDTH(AW), .AXI_DWIDTH(32)) dut (
    .AXI_ACLK    (clk),
    .AXI_ARESETN (rst_n),
    .AXI_AWADDR  (awaddr),
    .AXI_AWVALID (awvalid),
    .AXI_AWREADY (awready),
    .AXI_WDATA   (wdata),
    .AXI_WSTRB   (wstrb),
    .AXI_WVALID  (wvalid),
    .AXI_WREADY  (wready),
    .AXI_BRESP   (bresp),
    .AXI_BVALID  (bvalid),
    .AXI_BREADY  (bready),
    .AXI_ARADDR  (araddr),
    .AXI_ARVALID (arvalid),
    .AXI_ARREADY (arready),
    .AXI_RDATA   (rdata),
    .AXI_RRESP   (rresp),
    .AXI_RVALID  (rvalid),
    .AXI_RREADY  (rready)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    logic [1:0]    resp;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input string nm);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({nm, " aw/w ready timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check({nm, " bvalid"}, 32'(bvalid), 32'd1);
    check({nm, " bresp"}, 32'(bresp), 32'(exp_resp));
    @(negedge clk);
    check({nm, " bvalid drop"}, 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string nm);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({nm, " arready timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
`ifdef DMEM_READ_PIPE_EN
    check({nm, " rvalid early"}, 32'(rvalid), 32'd0);
    @(negedge clk);
`endif
    check({nm, " rvalid"}, 32'(rvalid), 32'd1);
    check({nm, " rdata"}, rdata, exp_data);
    check({nm, " rresp"}, 32'(rresp), 32'(exp_resp));
    @(negedge clk);
    check({nm, " rvalid drop"}, 32'(rvalid), 32'd0);
    check({nm, " arready back"}, 32'(arready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 13'h0010, 32'hA5A5_1234, 4'hF, 2'b00};
    vecs[1]  = '{1'b0, 13'h0010, 32'hA5A5_1234, 4'h0, 2'b00};
    vecs[2]  = '{1'b1, 13'h0020, 32'h0000_0000, 4'hF, 2'b00};
    vecs[3]  = '{1'b1, 13'h0000, 32'h0BAD_F00D, 4'hF, 2'b00};
    vecs[4]  = '{1'b1, 13'h0040, 32'h1122_3344, 4'hF, 2'b00};
    vecs[5]  = '{1'b1, 13'h0040, 32'hAABB_CCDD, 4'h8, 2'b00};
    vecs[6]  = '{1'b0, 13'h0040, 32'hAA22_3344, 4'h0, 2'b00};
    vecs[7]  = '{1'b0, 13'h1000, 32'h0000_0000, 4'h0, 2'b10};
    vecs[8]  = '{1'b0, 13'h0013, 32'h0000_0000, 4'h0, 2'b10};
    vecs[9]  = '{1'b1, 13'h1000, 32'hDEAD_BEEF, 4'hF, 2'b10};
    vecs[10] = '{1'b0, 13'h0000, 32'h0BAD_F00D, 4'h0, 2'b00};
    vecs[11] = '{1'b1, 13'h0011, 32'hDEAD_BEEF, 4'hF, 2'b10};
    vecs[12] = '{1'b0, 13'h0010, 32'hA5A5_1234, 4'h0, 2'b00};
    vecs[13] = '{1'b1, 13'h0010, 32'hFFFF_FFFF, 4'h0, 2'b00};
    vecs[14] = '{1'b0, 13'h0010, 32'hA5A5_1234, 4'h0, 2'b00};
    vecs[15] = '{1'b1, 13'h0030, 32'h0000_0001, 4'hF, 2'b00};
    vecs[16] = '{1'b1, 13'h0FFC, 32'h5A5A_5A5A, 4'hF, 2'b00};
    vecs[17] = '{1'b0, 13'h0FFC, 32'h5A5A_5A5A, 4'h0, 2'b00};
    vecs[18] = '{1'b0, 13'h1FFC, 32'h0000_0000, 4'h0, 2'b10};

    rst_n = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst arready", 32'(arready), 32'd0);
    check("rst awready", 32'(awready), 32'd0);
    check("rst wready", 32'(wready), 32'd0);
    check("rst rvalid", 32'(rvalid), 32'd0);
    check("rst bvalid", 32'(bvalid), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst rresp", 32'(rresp), 32'd0);
    check("rst bresp", 32'(bresp), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst arready", 32'(arready), 32'd1);
    check("post-rst awready", 32'(awready), 32'd1);
    check("post-rst wready", 32'(wready), 32'd1);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, $sformatf("vec%0d wr", i));
      else
        do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, $sformatf("vec%0d rd", i));
    end

    // W first, AW three cycles later, partial strobes over a zero word.
    wdata = 32'hFFFF_FFFF; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("wfirst wready low", 32'(wready), 32'd0);
    check("wfirst awready high", 32'(awready), 32'd1);
    check("wfirst no bvalid", 32'(bvalid), 32'd0);
    repeat (2) @(negedge clk);
    awaddr = 13'h0020; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("wfirst bvalid", 32'(bvalid), 32'd1);
    check("wfirst bresp", 32'(bresp), 32'd0);
    @(negedge clk);
    do_read(13'h0020, 32'h00FF_00FF, 2'b00, "wfirst readback");

    // Read backpressure: RDATA/RVALID held, ARREADY low.
    araddr = 13'h0010; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
`ifdef DMEM_READ_PIPE_EN
    @(negedge clk);
`endif
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rhold%0d rvalid", i), 32'(rvalid), 32'd1);
      check($sformatf("rhold%0d rdata", i), rdata, 32'hA5A5_1234);
      check($sformatf("rhold%0d arready", i), 32'(arready), 32'd0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    check("rhold release rvalid", 32'(rvalid), 32'd0);
    check("rhold release arready", 32'(arready), 32'd1);

    // Write backpressure: AWREADY/WREADY low until the B handshake.
    awaddr = 13'h0050; wdata = 32'h0000_0055; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bhold%0d bvalid", i), 32'(bvalid), 32'd1);
      check($sformatf("bhold%0d awready", i), 32'(awready), 32'd0);
      check($sformatf("bhold%0d wready", i), 32'(wready), 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    check("bhold release bvalid", 32'(bvalid), 32'd0);
    check("bhold release awready", 32'(awready), 32'd1);
    check("bhold release wready", 32'(wready), 32'd1);

    // Same-cycle read and write of one word returns the old contents.
    araddr = 13'h0030; arvalid = 1'b1; rready = 1'b1;
    awaddr = 13'h0030; wdata = 32'h0000_0002; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("rbw bvalid", 32'(bvalid), 32'd1);
`ifdef DMEM_READ_PIPE_EN
    @(negedge clk);
`endif
    check("rbw rvalid", 32'(rvalid), 32'd1);
    check("rbw old data", rdata, 32'h0000_0001);
    @(negedge clk);
    do_read(13'h0030, 32'h0000_0002, 2'b00, "rbw new data");

    // Reset while a read response is pending drops it.
    araddr = 13'h0010; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
`ifdef DMEM_READ_PIPE_EN
    @(negedge clk);
`endif
    check("midrst rvalid before", 32'(rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst rvalid", 32'(rvalid), 32'd0);
    check("midrst arready", 32'(arready), 32'd0);
    check("midrst rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst arready after", 32'(arready), 32'd1);
    check("midrst no stale rvalid", 32'(rvalid), 32'd0);
    rready = 1'b1;
    @(negedge clk);
    check("midrst still no rvalid", 32'(rvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
